uart_rx: RTL

- UART receiver; the receive-side counterpart of the TX_TOP serial transmitter.
- Deserialises an asynchronous frame on S_DATA: 1 start bit (0), DATA_WD data bits LSB first, an optional parity bit, and 1 stop bit (1). The line idles high.
- Oversamples each bit PRESCALE times and takes a 3-sample majority vote at mid-bit.
- Presents the received byte with a one-cycle valid pulse, plus parity and stop error pulses, to the system side.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop deserialiser with a 3-sample mid-bit majority vote.
// Registered DATA_VALID / PAR_ERR / STP_ERR pulses; early completion at mid-stop-bit allows back-to-back frames.
module uart_rx #(
    parameter int DATA_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               S_DATA,
    input  logic [5:0]         PRESCALE,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [DATA_WD-1:0] P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR,
    output logic               BUSY
);

    localparam int BCW = $clog2(DATA_WD + 1);

    // state  | meaning
    // IDLE   | line idle, waiting for a low level
    // START  | validating the start bit (glitch reject at mid-bit)
    // DATA   | shifting in DATA_WD bits, LSB first
    // PARITY | checking the parity bit against the shifted data
    // STOP   | voting the stop bit, completing at mid-bit
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         edge_q, edge_d;
    logic [BCW-1:0]     bit_q, bit_d;
    logic [5:0]         presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [1:0]         smp_q, smp_d;
    logic [DATA_WD-1:0] shift_q, shift_d;
    logic               par_mis_q, par_mis_d;
    logic [DATA_WD-1:0] p_data_q, p_data_d;
    logic               valid_q, valid_d;
    logic               par_err_q, par_err_d;
    logic               stp_err_q, stp_err_d;

    logic [5:0] half;
    logic       at_s0, at_s1, at_s2, at_end;
    logic       voted;
    logic       par_exp;

    assign half    = {1'b0, presc_q[5:1]};
    assign at_s0   = (edge_q == half - 6'd1);
    assign at_s1   = (edge_q == half);
    assign at_s2   = (edge_q == half + 6'd1);
    assign at_end  = (edge_q == presc_q - 6'd1);
    // third sample is the live line value at edge P/2+1
    assign voted   = (smp_q[0] & smp_q[1]) | (smp_q[0] & S_DATA) | (smp_q[1] & S_DATA);
    assign par_exp = par_typ_q ? ~^shift_q : ^shift_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            smp_q     <= '0;
            shift_q   <= '0;
            par_mis_q <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            smp_q     <= smp_d;
            shift_q   <= shift_d;
            par_mis_q <= par_mis_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        smp_d     = smp_q;
        shift_d   = shift_q;
        par_mis_d = par_mis_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;

        if (state_q != IDLE) begin
            edge_d = at_end ? 6'd0 : edge_q + 6'd1;
            if (at_s0) smp_d[0] = S_DATA;
            if (at_s1) smp_d[1] = S_DATA;
        end

        case (state_q)
            IDLE: begin
                edge_d = 6'd0;
                if (!S_DATA) begin
                    // detection cycle is edge 0 of the start bit
                    state_d   = START;
                    edge_d    = 6'd1;
                    bit_d     = '0;
                    presc_d   = PRESCALE;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_mis_d = 1'b0;
                end
            end
            START: begin
                if (at_s2 && voted) begin
                    state_d = IDLE;
                    edge_d  = 6'd0;
                end else if (at_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (at_s2) shift_d = {voted, shift_q[DATA_WD-1:1]};
                if (at_end) begin
                    if (bit_q == BCW'(DATA_WD - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_s2) par_mis_d = (voted != par_exp);
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_s2) begin
                    state_d   = IDLE;
                    edge_d    = 6'd0;
                    valid_d   = voted & ~par_mis_q;
                    par_err_d = par_mis_q;
                    stp_err_d = ~voted;
                    if (voted && !par_mis_q) p_data_d = shift_q;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = 6'd0;
            end
        endcase
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign BUSY       = (state_q != IDLE);

endmodule
